// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus launch controller feeding uart_tx.
// Bytes are launched one at a time with a registered tx_start pulse; the next
// launch waits for uart_tx's tx_done_tick.
// Optional build macro UART_TX_FIFO_WATERMARK_EN adds AF_LEVEL and almost_full.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | nothing in flight; pops and launches as soon as FIFO is non-empty
// ST_WAIT | a byte is in flight; waits for its tx_done_tick
module uart_tx_fifo #(
  parameter int DBIT  = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
`ifdef UART_TX_FIFO_WATERMARK_EN
  ,
  parameter int AF_LEVEL = DEPTH - 2
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [DBIT-1:0] wr_data,
  input  logic            clr_ovf,
  input  logic            tx_done_tick,
  output logic            tx_start,
  output logic [DBIT-1:0] tx_din,
  output logic            full,
  output logic            empty,
  output logic [AW:0]     count,
  output logic            busy,
  output logic            overflow
`ifdef UART_TX_FIFO_WATERMARK_EN
  ,
  output logic            almost_full
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t          state;
  logic [DBIT-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // full is the start-of-cycle value, so a push into a full FIFO is dropped
  // even when the FSM pops in the same cycle.
  assign push  = wr_en && !full;
  assign pop   = (state == ST_IDLE) && !empty;

`ifdef UART_TX_FIFO_WATERMARK_EN
  localparam logic [AW:0] AF_CNT = (AW+1)'(AF_LEVEL);
  assign almost_full = (count >= AF_CNT);
`endif

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally modulo DEPTH; count tracks occupancy separately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a dropped push wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  // Launch FSM with registered tx_start/tx_din/busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tx_start <= 1'b0;
      tx_din   <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_start <= 1'b0;
          if (!empty) begin
            tx_din   <= mem[rd_ptr];
            tx_start <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          tx_start <= 1'b0;
          // A tick coinciding with our own launch pulse belongs to the
          // previous frame.
          if (tx_done_tick && !tx_start) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          tx_start <= 1'b0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a byte scoreboard checked on every
// tx_start pulse.
module tb_uart_tx_fifo;

  localparam int DBIT  = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic            clk;
  logic            rst_n;
  logic            wr_en;
  logic [DBIT-1:0] wr_data;
  logic            clr_ovf;
  logic            tx_done_tick;
  logic            tx_start;
  logic [DBIT-1:0] tx_din;
  logic            full;
  logic            empty;
  logic [AW:0]     count;
  logic            busy;
  logic            overflow;
`ifdef UART_TX_FIFO_WATERMARK_EN
  logic            almost_full;
`endif

  logic man_done;
  logic auto_tick;
  logic auto_en;
  int   auto_cnt;

  int vectors;
  int miscompares;
  int starts;
  logic [DBIT-1:0] sb [$];

  assign tx_done_tick = man_done | auto_tick;

  uart_tx_fifo #(.DBIT(DBIT), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .clr_ovf      (clr_ovf),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .busy         (busy),
    .overflow     (overflow)
`ifdef UART_TX_FIFO_WATERMARK_EN
    ,
    .almost_full  (almost_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DBIT-1:0] b, input bit accepted);
    wr_en   = 1'b1;
    wr_data = b;
    if (accepted) sb.push_back(b);
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_done();
    man_done = 1'b1;
    step();
    man_done = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (!(empty && !busy) && n < budget) begin
      step();
      n++;
    end
    check(tag, {31'd0, empty && !busy}, 32'd1);
    check({tag, "_sb"}, sb.size(), 0);
  endtask

  // Scoreboard: every launch must present the oldest outstanding byte.
  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      starts++;
      if (sb.size() == 0) check("start_without_byte", sb.size(), 1);
      else check("tx_din_order", tx_din, sb.pop_front());
    end
  end

  // uart_tx stand-in: returns tx_done_tick 20 cycles after each launch.
  always @(negedge clk) begin
    auto_tick = 1'b0;
    if (auto_en && tx_start) begin
      auto_cnt = 20;
    end else if (auto_cnt > 0) begin
      auto_cnt--;
      if (auto_cnt == 0) auto_tick = 1'b1;
    end
  end

  initial begin
    int s0;
    vectors = 0; miscompares = 0; starts = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; clr_ovf = 1'b0;
    man_done = 1'b0; auto_en = 1'b0; auto_cnt = 0; auto_tick = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset values
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_din", tx_din, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);

    // Single byte: push at N, tx_start exactly at N+2
    push(8'hA5, 1'b1);
    check("single_n1_empty", empty, 0);
    check("single_n1_count", count, 1);
    check("single_n1_start", tx_start, 0);
    step();
    check("single_n2_start", tx_start, 1);
    check("single_n2_din", tx_din, 8'hA5);
    check("single_n2_busy", busy, 1);
    check("single_n2_count", count, 0);
    step();
    check("single_n3_start", tx_start, 0);
    check("single_n3_busy", busy, 1);
    pulse_done();
    check("single_done_busy", busy, 0);
    check("single_done_empty", empty, 1);
    repeat (5) step();
    check("single_start_count", starts, 1);

    // Burst ordering with 20-cycle responder
    auto_en = 1'b1;
    for (int i = 1; i <= 5; i++) push(DBIT'(i), 1'b1);
    wait_idle(400, "burst_drain");
    check("burst_starts", starts, 6);
    check("burst_count", count, 0);
    auto_en = 1'b0;
    repeat (3) step();

    // Fill / overflow with no done tick
    push(8'h00, 1'b1);
    step(); step();
    check("fill_busy", busy, 1);
    for (int i = 1; i <= 16; i++) push(DBIT'(i), 1'b1);
    check("fill_full_before_drop", full, 1);
    push(8'h11, 1'b0);
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    check("fill_overflow", overflow, 1);
    check("fill_starts", starts, 7);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    check("clr_overflow", overflow, 0);
    wr_en = 1'b1; wr_data = 8'h12; clr_ovf = 1'b1;
    step();
    wr_en = 1'b0; clr_ovf = 1'b0;
    check("ovf_set_wins", overflow, 1);
    check("ovf_count_held", count, 16);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    check("clr_overflow2", overflow, 0);
    auto_en = 1'b1;
    pulse_done();
    wait_idle(800, "fill_drain");
    check("fill_total_starts", starts, 23);
    auto_en = 1'b0;
    repeat (3) step();

    // Simultaneous push and pop at count = 3
    push(8'h40, 1'b1);
    step(); step();
    push(8'h41, 1'b1); push(8'h42, 1'b1); push(8'h43, 1'b1);
    check("simul_pre_count", count, 3);
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    auto_en = 1'b1;
    wr_en = 1'b1; wr_data = 8'h44; sb.push_back(8'h44);
    check("simul_idle_count", count, 3);
    check("simul_idle_busy", busy, 0);
    step();
    wr_en = 1'b0;
    check("simul_count", count, 3);
    check("simul_start", tx_start, 1);
    wait_idle(400, "simul_drain");
    auto_en = 1'b0;
    repeat (3) step();

    // Stray tick while idle and empty
    s0 = starts;
    pulse_done();
    check("stray_busy", busy, 0);
    step(); step();
    check("stray_start", tx_start, 0);
    check("stray_empty", empty, 1);
    check("stray_starts", starts, s0);

    // Tick coinciding with tx_start is ignored
    push(8'h55, 1'b1);
    step();
    check("coinc_start", tx_start, 1);
    pulse_done();
    check("coinc_busy", busy, 1);
    repeat (5) step();
    check("coinc_busy_hold", busy, 1);
    pulse_done();
    check("coinc_release", busy, 0);
    check("coinc_empty", empty, 1);
    repeat (3) step();

    // Reset mid-frame
    push(8'h60, 1'b1);
    step(); step();
    for (int i = 1; i <= 4; i++) push(DBIT'(8'h60 + i), 1'b0);
    check("mid_count", count, 4);
    check("mid_busy", busy, 1);
    s0 = starts;
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_din", tx_din, 0);
    check("mid_rst_start", tx_start, 0);
    check("mid_rst_full", full, 0);
    check("mid_rst_ovf", overflow, 0);
    step();
    rst_n = 1'b1;
    pulse_done();
    repeat (5) step();
    check("mid_post_starts", starts, s0);
    check("mid_post_busy", busy, 0);
    check("mid_post_empty", empty, 1);
    check("final_sb", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte FIFO and launch controller sitting directly upstream of uart_tx.
- Accepts bytes from a producer (CPU/test logic) at any rate up to one per clock.
- Feeds uart_tx one byte at a time: drives its din and a one-cycle tx_start pulse, then waits for uart_tx's tx_done_tick before launching the next byte.
- Replaces the free-running tx_start counter with data-driven launches.

Parameters:
- DBIT, 8: data width in bits.
- DEPTH, 16: FIFO entries; must be a power of 2, minimum 2.
- AW, $clog2(DEPTH): pointer width (derived; do not override).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  push request
- wr_data  in  DBIT  byte to push
- clr_ovf  in  1  clears the overflow flag
- tx_done_tick  in  1  one-cycle pulse from uart_tx at end of stop bit
- tx_start  out  1  one-cycle launch pulse to uart_tx
- tx_din  out  DBIT  byte presented to uart_tx; held stable until the next launch
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO holds 0 entries
- count  out  AW+1  current occupancy, 0..DEPTH
- busy  out  1  a byte has been launched and its tx_done_tick is not yet seen
- overflow  out  1  sticky: a push was dropped

Behaviour:
- Reset (async assert, sync release). Pointers = 0, count = 0, empty = 1, full = 0, tx_start = 0, tx_din = 0, busy = 0, overflow = 0, FSM = IDLE.
- Storage. Register array with rd_ptr/wr_ptr of AW bits that wrap naturally modulo DEPTH. count is a separate AW+1 counter. full = (count == DEPTH); empty = (count == 0). Both are combinational from count.
- Push. wr_en && !full writes wr_data at wr_ptr, and wr_ptr increments.
- Push while full. full is evaluated at the start of the cycle. A push is dropped even if a pop occurs in the same cycle. A dropped push sets overflow.
- Overflow flag. overflow stays set until clr_ovf. If clr_ovf and a dropped push coincide, set wins.
- Pop. Only the FSM pops. The popped entry is registered into tx_din and rd_ptr increments.
- Count update. Simultaneous accepted push and pop leaves count unchanged. Otherwise count goes +1 on push or -1 on pop.
- FSM state IDLE. If !empty: pop, assert tx_start next cycle (registered), set busy, go to WAIT. Else stay.
- FSM state WAIT. tx_start is high only in the first WAIT cycle. On tx_done_tick: clear busy, go to IDLE. The earliest next tx_start is therefore 2 cycles after tx_done_tick.
- tx_done_tick in IDLE is ignored. tx_done_tick in the same cycle as tx_start is treated as belonging to the previous frame and ignored.
- Latency. wr_en at cycle N into an empty FIFO with FSM in IDLE gives empty = 0 at N+1, the pop at N+1, and tx_start = 1 with tx_din valid at N+2.
- Ordering. Bytes are transmitted strictly in push order, with no duplication or loss except dropped overflow pushes.
- Reset mid-frame. All state clears immediately and FIFO contents are discarded. A tx_done_tick from the in-flight frame arriving after reset is ignored because the FSM is in IDLE.

Optional Feature:
Macro UART_TX_FIFO_WATERMARK_EN.
- Defined: adds parameter AF_LEVEL (default DEPTH-2) and output almost_full (1 bit), asserted combinationally when count >= AF_LEVEL. Reset value 0.
- Undefined: neither the parameter nor the port exists. All other behaviour is identical.

Test Plan:
- Single byte: push 0xA5 into an empty FIFO at cycle N -> tx_start high only at N+2 with tx_din = 0xA5, busy = 1. Pulse tx_done_tick -> busy = 0, empty = 1, no further tx_start.
- Burst ordering: push 0x01..0x05 on consecutive cycles, with tx_done_tick returned 20 cycles after each tx_start -> exactly 5 tx_start pulses with tx_din = 0x01,0x02,0x03,0x04,0x05 in order, count returns to 0.
- Fill/overflow with tx_done_tick never returned: 1st push (0x00) is launched. Push 17 more bytes 0x01..0x11 -> the first 16 fill the FIFO (full = 1, count = 16), 0x11 is dropped, overflow = 1. Pulse clr_ovf -> overflow = 0.
- Simultaneous push/pop at count = 3: push while FSM pops -> count stays 3, new byte appended at tail.
- Stray and coincident tx_done_tick: tick while IDLE/empty -> no effect. Tick in the tx_start cycle -> busy stays 1 until the next tick.
- Reset mid-frame: with count = 4 and busy = 1, assert rst_n low for 1 cycle -> all outputs at reset values. A later tx_done_tick produces no tx_start.
